execute_stage: RTL and testbench

- Execute (EX) stage of the 5-stage RV32I pipelined CPU. Sits directly downstream of the decode stage and consumes its ID/EX register outputs.
- Applies hazard-unit forwarding to both operands, runs the ALU, and resolves beq/jal. It drives PCTargetE and PCSrcE back to fetch.
- Registers the memory-stage control and data into the EX/MEM pipeline register, which supports stall and flush.

---
 rtl/execute_stage.sv | 136 +++++++++++++
 tb/tb_execute_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32I execute stage: operand forwarding, ALU, branch resolve, EX/MEM register
module execute_stage #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   PCE,
  input  logic [WIDTH-1:0]   PCPlus4E,
  input  logic [WIDTH-1:0]   ImmExtE,
  input  logic [WIDTH-1:0]   RD1E,
  input  logic [WIDTH-1:0]   RD2E,
  input  logic [REGADDR-1:0] RdE,
  input  logic               RegWriteE,
  input  logic               MemWriteE,
  input  logic               JumpE,
  input  logic               BranchE,
  input  logic               ALUSrcE,
  input  logic [1:0]         ResultSrcE,
  input  logic [2:0]         ALUControlE,
  input  logic [1:0]         ForwardAE,
  input  logic [1:0]         ForwardBE,
  input  logic [WIDTH-1:0]   ResultW,
  input  logic               StallM,
  input  logic               FlushM,
  output logic [WIDTH-1:0]   PCTargetE,
  output logic               PCSrcE,
  output logic [WIDTH-1:0]   ALUResultM,
  output logic [WIDTH-1:0]   WriteDataM,
  output logic [WIDTH-1:0]   PCPlus4M,
  output logic [REGADDR-1:0] RdM,
  output logic               RegWriteM,
  output logic               MemWriteM,
  output logic [1:0]         ResultSrcM
);

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] write_data_e;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_result;
  logic             zero_e;

  logic [WIDTH-1:0]   alu_result_q, alu_result_d;
  logic [WIDTH-1:0]   write_data_q, write_data_d;
  logic [WIDTH-1:0]   pc_plus4_q, pc_plus4_d;
  logic [REGADDR-1:0] rd_q, rd_d;
  logic               reg_write_q, reg_write_d;
  logic               mem_write_q, mem_write_d;
  logic [1:0]         result_src_q, result_src_d;

  // Reserved forward select 11 falls back to the register-file value.
  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = alu_result_q;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   write_data_e = ResultW;
      2'b10:   write_data_e = alu_result_q;
      default: write_data_e = RD2E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtE : write_data_e;

  always_comb begin
    case (ALUControlE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign zero_e    = (alu_result == '0);
  assign PCTargetE = PCE + ImmExtE;
  assign PCSrcE    = JumpE | (BranchE & zero_e);

  // Flush zeroes only the controls; the data fields are harmless once RegWrite/MemWrite are 0.
  always_comb begin
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    pc_plus4_d   = pc_plus4_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    result_src_d = result_src_q;
    if (FlushM || !StallM) begin
      alu_result_d = alu_result;
      write_data_d = write_data_e;
      pc_plus4_d   = PCPlus4E;
      rd_d         = RdE;
      reg_write_d  = RegWriteE;
      mem_write_d  = MemWriteE;
      result_src_d = ResultSrcE;
    end
    if (FlushM) begin
      rd_d         = '0;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      result_src_d = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 2'b00;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
    end
  end

  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;
  assign RdM        = rd_q;
  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - randomized and directed bench for execute_stage against a behavioural model
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCE, PCPlus4E, ImmExtE, RD1E, RD2E, ResultW;
  logic [4:0]  RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0]  ALUControlE;
  logic        StallM, FlushM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic        PCSrcE, RegWriteM, MemWriteM;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the EX/MEM register contents.
  logic [31:0] m_alu, m_wd, m_pc4;
  logic [4:0]  m_rd;
  logic        m_rw, m_mw;
  logic [1:0]  m_rs;

  execute_stage dut (
    .clk(clk), .reset(reset), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .RD1E(RD1E), .RD2E(RD2E), .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .StallM(StallM), .FlushM(FlushM), .PCTargetE(PCTargetE),
    .PCSrcE(PCSrcE), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                       input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return mem;
    return rf;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a; sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0; m_rw = 0; m_mw = 0; m_rs = 0;
  endtask

  task automatic check_m(input string where);
    check_eq({where, ".ALUResultM"}, ALUResultM, m_alu);
    check_eq({where, ".WriteDataM"}, WriteDataM, m_wd);
    check_eq({where, ".PCPlus4M"}, PCPlus4M, m_pc4);
    check_eq({where, ".RdM"}, {27'd0, RdM}, {27'd0, m_rd});
    check_eq({where, ".RegWriteM"}, {31'd0, RegWriteM}, {31'd0, m_rw});
    check_eq({where, ".MemWriteM"}, {31'd0, MemWriteM}, {31'd0, m_mw});
    check_eq({where, ".ResultSrcM"}, {30'd0, ResultSrcM}, {30'd0, m_rs});
  endtask

  // One pipeline cycle: check combinational outputs, clock, update model, check M outputs.
  task automatic cycle(input string where);
    logic [31:0] a, wd, r;
    logic        redirect;
    #1;
    a  = pick(ForwardAE, RD1E, ResultW, m_alu);
    wd = pick(ForwardBE, RD2E, ResultW, m_alu);
    r  = alu_ref(ALUControlE, a, ALUSrcE ? ImmExtE : wd);
    redirect = JumpE || (BranchE && r == 32'd0);
    check_eq({where, ".PCTargetE"}, PCTargetE, PCE + ImmExtE);
    check_eq({where, ".PCSrcE"}, {31'd0, PCSrcE}, {31'd0, redirect});
    @(posedge clk);
    if (!reset) model_reset();
    else if (FlushM) begin
      m_alu = r; m_wd = wd; m_pc4 = PCPlus4E;
      m_rd = 0; m_rw = 0; m_mw = 0; m_rs = 0;
    end else if (!StallM) begin
      m_alu = r; m_wd = wd; m_pc4 = PCPlus4E;
      m_rd = RdE; m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE;
    end
    #1;
    check_m(where);
  endtask

  task automatic idle_inputs();
    PCE = 0; PCPlus4E = 0; ImmExtE = 0; RD1E = 0; RD2E = 0; ResultW = 0; RdE = 0;
    RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; ALUSrcE = 0;
    ResultSrcE = 0; ForwardAE = 0; ForwardBE = 0; ALUControlE = 0; StallM = 0; FlushM = 0;
  endtask

  task automatic alu_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    idle_inputs();
    ALUControlE = op; RD1E = a; RD2E = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fwd_exp [4];
    fwd_exp[0] = 3; fwd_exp[1] = 42; fwd_exp[2] = 102; fwd_exp[3] = 3;
    idle_inputs();
    model_reset();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    check_m("reset");
    #3 reset = 1;

    // Asynchronous reset mid-stream.
    alu_op(3'd0, 32'h1234, 0); RegWriteE = 1; RdE = 5; PCPlus4E = 32'h44;
    cycle("load1234");
    check_eq("pre_reset_alu", ALUResultM, 32'h1234);
    #2 reset = 0;
    #1 model_reset();
    check_m("async_reset");
    #1 reset = 1;
    alu_op(3'd0, 5, 7);
    cycle("post_reset_add");
    check_eq("add_5_7", ALUResultM, 32'd12);

    // Directed ALU operations.
    alu_op(3'd1, 3, 5);              cycle("sub");  check_eq("sub_3_5", ALUResultM, 32'hFFFFFFFE);
    alu_op(3'd5, 32'hFFFFFFFF, 1);   cycle("slt1"); check_eq("slt_m1_1", ALUResultM, 32'd1);
    alu_op(3'd5, 1, 32'hFFFFFFFF);   cycle("slt2"); check_eq("slt_1_m1", ALUResultM, 32'd0);
    alu_op(3'd2, 32'hF0F0, 32'h0FF0); cycle("and"); check_eq("and", ALUResultM, 32'h00F0);
    alu_op(3'd3, 32'hF0F0, 32'h0FF0); cycle("or");  check_eq("or", ALUResultM, 32'hFFF0);
    alu_op(3'd0, 32'hFFFFFFFF, 1);   cycle("wrap"); check_eq("add_wrap", ALUResultM, 32'd0);
    alu_op(3'd7, 32'h55, 32'h66);    cycle("op7");  check_eq("alu_op7", ALUResultM, 32'd0);

    // Forwarding: re-establish ALUResultM=100 before each select.
    for (int s = 0; s < 4; s++) begin
      alu_op(3'd0, 100, 0); cycle("fwd_setup");
      alu_op(3'd0, 1, 0); ResultW = 40; ImmExtE = 2; ALUSrcE = 1; ForwardAE = s[1:0];
      cycle("fwdA");
      check_eq($sformatf("fwdA_%0d", s), ALUResultM, fwd_exp[s]);
    end
    alu_op(3'd0, 100, 0); cycle("fwdB_setup");
    alu_op(3'd0, 0, 9); ForwardBE = 2'b10; MemWriteE = 1;
    cycle("fwdB");
    check_eq("fwdB_wdata", WriteDataM, 32'd100);
    check_eq("fwdB_memwrite", {31'd0, MemWriteM}, 32'd1);

    // Branch and jump resolution.
    alu_op(3'd1, 77, 77); BranchE = 1; PCE = 32'h100; ImmExtE = 32'hFFFFFFF8;
    #1;
    check_eq("beq_taken", {31'd0, PCSrcE}, 32'd1);
    check_eq("beq_target", PCTargetE, 32'hF8);
    cycle("beq_eq");
    alu_op(3'd1, 77, 78); BranchE = 1;
    #1 check_eq("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
    cycle("beq_ne");
    alu_op(3'd1, 1, 2); JumpE = 1; PCPlus4E = 32'h204;
    #1 check_eq("jal_taken", {31'd0, PCSrcE}, 32'd1);
    cycle("jal");
    check_eq("jal_pc4", PCPlus4M, 32'h204);

    // Stall holds every M output.
    alu_op(3'd0, 10, 20); RdE = 9; RegWriteE = 1;
    cycle("pre_stall");
    for (int i = 0; i < 3; i++) begin
      alu_op(3'd0, 1000 + i, 1); RdE = 5'(i + 20); StallM = 1; MemWriteE = 1;
      cycle("stall");
      check_eq("stall_alu", ALUResultM, 32'd30);
      check_eq("stall_rd", {27'd0, RdM}, 32'd9);
    end

    // Flush, and flush taking priority over stall.
    for (int i = 0; i < 2; i++) begin
      alu_op(3'd0, 4, 4); RegWriteE = 1; RdE = 7; ResultSrcE = 2'b01; FlushM = 1; StallM = 1'(i);
      cycle("flush");
      check_eq($sformatf("flush%0d_rw", i), {31'd0, RegWriteM}, 32'd0);
      check_eq($sformatf("flush%0d_rd", i), {27'd0, RdM}, 32'd0);
    end

    // Back-to-back stream.
    for (int i = 1; i <= 4; i++) begin
      alu_op(3'd0, i, i); RdE = 5'(i); RegWriteE = 1;
      cycle("stream");
      check_eq($sformatf("stream_rd%0d", i), {27'd0, RdM}, i);
    end

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      PCE = $urandom; PCPlus4E = PCE + 4; ImmExtE = $urandom; ResultW = $urandom;
      RD1E = $urandom; RD2E = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
      if ($urandom_range(0, 1) == 0) begin
        RD1E = $urandom_range(0, 3) - 1; RD2E = $urandom_range(0, 3) - 1;
      end
      RdE = 5'($urandom); RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
      JumpE = ($urandom_range(0, 3) == 0); BranchE = 1'($urandom); ALUSrcE = 1'($urandom);
      ResultSrcE = 2'($urandom); ALUControlE = 3'($urandom);
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      StallM = ($urandom_range(0, 7) == 0); FlushM = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
